// File: rtl/pdm_voice_synth.sv
// Single-voice synth: NCO, waveform select, gated envelope, amplitude scaling, first-order PDM.
// Optional vibrato LFO enabled by defining PDM_VOICE_LFO_EN (adds lfo_depth / lfo_out ports).
module pdm_voice_synth #(
    parameter int CLKSPEED    = 48_000_000,
    parameter int SAMPLE_RATE = 48_000,
    parameter int PHASE_W     = 24,
    parameter int OUT_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gate,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    input  logic [OUT_W-1:0]   amp_in,
    input  logic [OUT_W-1:0]   env_rate,
`ifdef PDM_VOICE_LFO_EN
    input  logic [OUT_W-1:0]   lfo_depth,
    output logic [0:0]         lfo_out,
`endif
    output logic               dout,
    output logic [OUT_W-1:0]   sample,
    output logic               sample_valid,
    output logic               busy
);
    localparam int DIV   = CLKSPEED / SAMPLE_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [OUT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

    env_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [1:0]         vld_pipe;
    logic [PHASE_W-1:0] phase, phase_inc;
    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic [OUT_W-1:0]   p, wave, wave_r, amp_r;
    logic [OUT_W-1:0]   env, env_n, env_up, env_dn;
    logic [OUT_W:0]     env_sum;
    logic [2*OUT_W-1:0] prod_we, prod_ta;
    logic [OUT_W-1:0]   pdm_acc;
    logic [OUT_W:0]     pdm_sum;

    assign tick    = (cnt == CNT_W'(DIV - 1));
    assign p       = phase[PHASE_W-1 -: OUT_W];
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign busy    = (state != IDLE);
    assign sample_valid = vld_pipe[1];

`ifdef PDM_VOICE_LFO_EN
    logic [15:0]        lfo_cnt;
    logic [OUT_W-1:0]   lfo_tri;
    logic [2*OUT_W-1:0] lfo_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfo_cnt <= '0;
        else if (tick) lfo_cnt <= lfo_cnt + 16'd1;
    end

    assign lfo_tri   = lfo_cnt[15] ? ~lfo_cnt[14 -: OUT_W] : lfo_cnt[14 -: OUT_W];
    assign lfo_prod  = {{OUT_W{1'b0}}, lfo_tri} * {{OUT_W{1'b0}}, lfo_depth};
    assign phase_inc = freq_word + PHASE_W'(lfo_prod >> (2*OUT_W - 8));
    assign lfo_out   = lfo_cnt[15];
`else
    assign phase_inc = freq_word;
`endif

    always_comb begin
        wave = p;
        case (wave_sel)
            2'd0:    wave = p;
            2'd1:    wave = p[OUT_W-1] ? MAX : '0;
            2'd2:    wave = p[OUT_W-1] ? ~{p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
            default: wave = lfsr[15 -: OUT_W];
        endcase
    end

    // Gate decides the direction first, so the tick that changes state also takes its step.
    always_comb begin
        state_n = state;
        env_n   = env;
        env_sum = {1'b0, env} + {1'b0, env_rate};
        env_up  = (env_rate == '0 || env_sum[OUT_W]) ? MAX : env_sum[OUT_W-1:0];
        env_dn  = (env_rate == '0 || env < env_rate) ? '0 : env - env_rate;
        if (gate) begin
            if (state != SUSTAIN) begin
                env_n   = env_up;
                state_n = (env_up == MAX) ? SUSTAIN : ATTACK;
            end
        end else if (state != IDLE) begin
            env_n   = env_dn;
            state_n = (env_dn == '0) ? IDLE : RELEASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            env   <= '0;
        end else if (tick) begin
            state <= state_n;
            env   <= env_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            vld_pipe <= '0;
            phase    <= '0;
            lfsr     <= 16'hACE1;
            wave_r   <= '0;
            amp_r    <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + CNT_W'(1);
            vld_pipe <= {vld_pipe[0], tick};
            if (tick) begin
                phase  <= phase + phase_inc;
                lfsr   <= {lfsr[14:0], lfsr_fb};
                wave_r <= wave;
                amp_r  <= amp_in;
            end
        end
    end

    // Scaling runs the cycle after the tick so it sees the freshly updated envelope.
    assign prod_we = {{OUT_W{1'b0}}, wave_r} * {{OUT_W{1'b0}}, env};
    assign prod_ta = {{OUT_W{1'b0}}, prod_we[2*OUT_W-1:OUT_W]} * {{OUT_W{1'b0}}, amp_r};
    assign pdm_sum = {1'b0, pdm_acc} + {1'b0, sample};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample  <= '0;
            pdm_acc <= '0;
            dout    <= 1'b0;
        end else begin
            if (vld_pipe[0]) sample <= prod_ta[2*OUT_W-1:OUT_W];
            pdm_acc <= pdm_sum[OUT_W-1:0];
            dout    <= pdm_sum[OUT_W];
        end
    end
endmodule

// File: tb/tb_pdm_voice_synth.sv
// Bench for pdm_voice_synth (DIV=10, PHASE_W=16, OUT_W=10) against an arithmetic per-tick model.
module tb_pdm_voice_synth;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] freq_word = '0;
    logic [1:0]  wave_sel = '0;
    logic [9:0]  amp_in = '0;
    logic [9:0]  env_rate = '0;
    logic        dout;
    logic [9:0]  sample;
    logic        sample_valid;
    logic        busy;
`ifdef PDM_VOICE_LFO_EN
    logic [9:0]  lfo_depth = '0;
    logic [0:0]  lfo_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int          m_phase, m_env, m_sample;
    logic [15:0] m_lfsr;

    pdm_voice_synth #(.CLKSPEED(1000), .SAMPLE_RATE(100), .PHASE_W(16), .OUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .gate(gate), .freq_word(freq_word), .wave_sel(wave_sel),
        .amp_in(amp_in), .env_rate(env_rate),
`ifdef PDM_VOICE_LFO_EN
        .lfo_depth(lfo_depth), .lfo_out(lfo_out),
`endif
        .dout(dout), .sample(sample), .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_env = 0; m_sample = 0; m_lfsr = 16'hACE1;
    endtask

    // One sample period: wave from the old phase, envelope after this tick's step.
    task automatic model_step();
        int p, w, r;
        logic fb;
        p = m_phase / 64;
        r = int'(env_rate);
        case (wave_sel)
            2'd0:    w = p;
            2'd1:    w = (p >= 512) ? 1023 : 0;
            2'd2:    w = (p >= 512) ? 1023 - ((2 * p) % 1024) : (2 * p) % 1024;
            default: w = int'(m_lfsr) / 64;
        endcase
        if (gate) m_env = (r == 0 || m_env + r > 1023) ? 1023 : m_env + r;
        else      m_env = (r == 0 || m_env < r) ? 0 : m_env - r;
        m_sample = (((w * m_env) / 1024) * int'(amp_in)) / 1024;
        m_phase  = (m_phase + int'(freq_word)) % 65536;
        fb       = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr   = {m_lfsr[14:0], fb};
    endtask

    task automatic next_tick(output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < 40) begin
            @(negedge clk);
            if (sample_valid === 1'b1) ok = 1'b1;
            i++;
        end
        if (ok) model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        gate = 0; freq_word = 16'h1000; wave_sel = 0; amp_in = 1023; env_rate = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dout, sample_valid, busy} !== 3'b000 || sample !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: dout=%b valid=%b busy=%b sample=%0d, want all 0",
                     dout, sample_valid, busy, sample);
        end
        rst_n = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (sample_valid === 1'b1) seen = 1;
        end
        n_checks++;
        if (n != 11) begin
            n_errors++;
            $display("FAIL first_valid_latency: got %0d clks, want 11", n);
        end
        model_step();
        n_checks++;
        if (sample !== 10'(m_sample) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL first_sample: sample=%0d busy=%b, want %0d busy=0", sample, busy, m_sample);
        end
    endtask

    task automatic test_saw();
        bit ok;
        gate = 1; freq_word = 16'h1000; wave_sel = 0; amp_in = 1023; env_rate = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            next_tick(ok);
            n_checks++;
            if (!ok || sample !== 10'(m_sample) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL saw[%0d]: ok=%b sample=%0d busy=%b, want %0d busy=1", i, ok, sample, busy, m_sample);
            end
        end
    endtask

    // Parks phase at 0x8000 so the square wave sits at full scale from the next tick on.
    task automatic prime_square(input int rate, input int amp);
        bit ok;
        gate = 0; freq_word = 16'h8000; wave_sel = 1; amp_in = 10'(amp); env_rate = 10'(rate);
        do_reset();
        next_tick(ok);
        freq_word = 16'h0000;
    endtask

    task automatic test_envelope();
        int  env_exp[10] = '{256, 512, 768, 1023, 1023, 767, 511, 255, 0, 0};
        bit  g[10]       = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int  exp_s;
        bit  ok;
        prime_square(256, 1023);
        for (int i = 0; i < 10; i++) begin
            gate = g[i];
            next_tick(ok);
            exp_s = (((1023 * env_exp[i]) / 1024) * 1023) / 1024;
            n_checks++;
            if (!ok || sample !== 10'(exp_s) || busy !== (env_exp[i] != 0)) begin
                n_errors++;
                $display("FAIL envelope[%0d]: sample=%0d busy=%b, want %0d busy=%b",
                         i, sample, busy, exp_s, env_exp[i] != 0);
            end
        end
    endtask

    task automatic test_retrigger();
        int env_exp[8] = '{256, 512, 768, 1023, 767, 511, 767, 1023};
        bit g[8]       = '{1, 1, 1, 1, 0, 0, 1, 1};
        int exp_s;
        bit ok;
        prime_square(256, 1023);
        for (int i = 0; i < 8; i++) begin
            gate = g[i];
            next_tick(ok);
            exp_s = (((1023 * env_exp[i]) / 1024) * 1023) / 1024;
            n_checks++;
            if (!ok || sample !== 10'(exp_s) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL retrigger[%0d]: sample=%0d busy=%b, want %0d busy=1", i, sample, busy, exp_s);
            end
        end
    endtask

    task automatic test_pdm();
        int  ones;
        bit  ok;
        logic prev;
        prime_square(0, 514);
        gate = 1;
        next_tick(ok);
        next_tick(ok);
        n_checks++;
        if (!ok || sample !== 10'd512) begin
            n_errors++;
            $display("FAIL pdm_half_sample: sample=%0d, want 512", sample);
        end
        repeat (2) @(negedge clk);
        prev = dout;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_checks++;
            if (dout === prev) begin
                n_errors++;
                $display("FAIL pdm_alternate[%0d]: dout=%b repeated", i, dout);
            end
            prev = dout;
        end
        ones = 0;
        for (int i = 0; i < 1024; i++) begin @(negedge clk); if (dout === 1'b1) ones++; end
        n_checks++;
        if (ones != 512) begin
            n_errors++;
            $display("FAIL pdm_density_512: ones=%0d, want 512", ones);
        end
        // Largest reachable sample: (1023*1023>>10)*1023>>10 = 1021 -> three zeros per 1024 clks.
        amp_in = 1023;
        next_tick(ok);
        n_checks++;
        if (!ok || sample !== 10'd1021) begin
            n_errors++;
            $display("FAIL pdm_full_sample: sample=%0d, want 1021", sample);
        end
        repeat (2) @(negedge clk);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin @(negedge clk); if (dout === 1'b1) ones++; end
        n_checks++;
        if (1024 - ones != 3) begin
            n_errors++;
            $display("FAIL pdm_density_full: zeros=%0d, want 3", 1024 - ones);
        end
        amp_in = 0;
        next_tick(ok);
        repeat (2) @(negedge clk);
        ones = 0;
        for (int i = 0; i < 300; i++) begin @(negedge clk); if (dout !== 1'b0) ones++; end
        n_checks++;
        if (!ok || sample !== 10'd0 || ones != 0) begin
            n_errors++;
            $display("FAIL pdm_zero: sample=%0d nonzero_dout=%0d, want 0 and 0", sample, ones);
        end
    endtask

    task automatic test_wrap_noise();
        bit ok;
        gate = 1; freq_word = 16'hFFFF; wave_sel = 0; amp_in = 1023; env_rate = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_tick(ok);
            n_checks++;
            if (!ok || sample !== 10'(m_sample)) begin
                n_errors++;
                $display("FAIL wrap[%0d]: sample=%0d, want %0d", i, sample, m_sample);
            end
        end
        wave_sel = 3;
        for (int i = 0; i < 100; i++) begin
            next_tick(ok);
            n_checks++;
            if (!ok || sample !== 10'(m_sample)) begin
                n_errors++;
                $display("FAIL noise[%0d]: sample=%0d, want %0d", i, sample, m_sample);
            end
        end
    endtask

    // Random settings per period, with junk driven early in each period that must be ignored.
    task automatic test_random();
        bit          ok, g;
        logic [15:0] fw;
        logic [1:0]  ws;
        logic [9:0]  amp, rate;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            g    = ($urandom_range(0, 3) != 0) ? ~gate : gate;
            g    = (i % 12 < 7) ? 1'b1 : g;
            fw   = 16'($urandom);
            ws   = 2'($urandom_range(0, 3));
            amp  = 10'($urandom_range(0, 1023));
            rate = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 400));
            gate = ~g; freq_word = 16'($urandom); wave_sel = ~ws; amp_in = ~amp; env_rate = ~rate;
            repeat (3) @(negedge clk);
            gate = g; freq_word = fw; wave_sel = ws; amp_in = amp; env_rate = rate;
            next_tick(ok);
            n_checks++;
            if (!ok || sample !== 10'(m_sample) || busy !== (m_env != 0)) begin
                n_errors++;
                $display("FAIL random[%0d]: sample=%0d busy=%b, want %0d busy=%b",
                         i, sample, busy, m_sample, m_env != 0);
            end
        end
    endtask

    task automatic test_reset_midrelease();
        bit ok, seen;
        int ones, n;
        gate = 1; freq_word = 16'h1000; wave_sel = 0; amp_in = 1023; env_rate = 64;
        do_reset();
        for (int i = 0; i < 18; i++) next_tick(ok);
        gate = 0;
        next_tick(ok);
        next_tick(ok);
        n_checks++;
        if (!ok || busy !== 1'b1 || sample !== 10'(m_sample)) begin
            n_errors++;
            $display("FAIL release_state: sample=%0d busy=%b, want %0d busy=1", sample, busy, m_sample);
        end
        ones = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (dout === 1'b1) ones++; end
        n_checks++;
        if ((ones > 0) != (m_sample > 1000)) begin
            // 4 clks guarantee a one only for large samples; check activity over a longer span instead
            for (int i = 0; i < 4; i++) begin @(negedge clk); if (dout === 1'b1) ones++; end
        end
        if ((ones > 0) != (m_sample > 0)) begin
            n_errors++;
            $display("FAIL release_pdm_activity: ones=%0d for sample %0d", ones, m_sample);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dout, sample_valid, busy} !== 3'b000 || sample !== 10'd0) begin
            n_errors++;
            $display("FAIL async_reset: dout=%b valid=%b busy=%b sample=%0d, want all 0",
                     dout, sample_valid, busy, sample);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (sample_valid === 1'b1) seen = 1;
        end
        model_step();
        n_checks++;
        if (n != 11 || sample !== 10'(m_sample) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_restart: latency=%0d sample=%0d busy=%b, want 11 %0d 0", n, sample, busy, m_sample);
        end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_envelope();
        test_retrigger();
        test_pdm();
        test_wrap_noise();
        test_random();
        test_reset_midrelease();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
